// File: rtl/pipe_stage_chain.sv
// N-stage pipeline register chain with per-stage stall, flush and bubble insertion.
// Debug run/step control, cycle counter and a registered stage-snapshot port.
module pipe_stage_chain #(
  parameter int NUM_STAGES = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16,
  parameter int CYC_WIDTH  = 32,
  parameter int SEL_WIDTH  = $clog2(NUM_STAGES)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [DATA_WIDTH-1:0]            i_data,
  input  logic                             i_valid,
  input  logic [NUM_STAGES-1:0]            i_stall,
  input  logic [NUM_STAGES-1:0]            i_flush,
  input  logic                             i_mode,
  input  logic                             i_step_load,
  input  logic [CNT_WIDTH-1:0]             i_step_count,
  input  logic [SEL_WIDTH-1:0]             i_snap_sel,
  output logic [NUM_STAGES*DATA_WIDTH-1:0] o_stage_data,
  output logic [NUM_STAGES-1:0]            o_stage_valid,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  output logic                             o_ready,
  output logic                             o_halted,
  output logic [CNT_WIDTH-1:0]             o_step_left,
  output logic [CYC_WIDTH-1:0]             o_cycle_count,
  output logic [DATA_WIDTH-1:0]            o_snap_data,
  output logic                             o_snap_valid
);

  logic [DATA_WIDTH-1:0] data_q [NUM_STAGES];
  logic [DATA_WIDTH-1:0] data_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] hold;
  logic [CNT_WIDTH-1:0]  step_q, step_d;
  logic [CYC_WIDTH-1:0]  cyc_q, cyc_d;
  logic [DATA_WIDTH-1:0] snap_data_q, snap_data_d;
  logic                  snap_valid_q, snap_valid_d;
  logic                  adv;

  assign adv = !i_mode || (step_q != '0);

  // A stall anywhere downstream freezes every stage upstream of it.
  always_comb begin
    hold = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      hold[k] = |(i_stall >> k);
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      data_d[k]  = data_q[k];
      valid_d[k] = valid_q[k];
    end
    if (adv) begin
      if (i_flush[0]) begin
        data_d[0]  = '0;
        valid_d[0] = 1'b0;
      end else if (!hold[0]) begin
        data_d[0]  = i_data;
        valid_d[0] = i_valid;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (i_flush[k]) begin
          data_d[k]  = '0;
          valid_d[k] = 1'b0;
        end else if (hold[k]) begin
          data_d[k]  = data_q[k];
          valid_d[k] = valid_q[k];
        end else if (hold[k-1]) begin
          data_d[k]  = '0;
          valid_d[k] = 1'b0;
        end else begin
          data_d[k]  = data_q[k-1];
          valid_d[k] = valid_q[k-1];
        end
      end
    end
  end

  always_comb begin
    step_d = step_q;
    if (i_step_load) begin
      step_d = i_step_count;
    end else if (i_mode && step_q != '0) begin
      step_d = step_q - CNT_WIDTH'(1);
    end
  end

  assign cyc_d = adv ? cyc_q + CYC_WIDTH'(1) : cyc_q;

  // Out-of-range selects match no stage and read as zero.
  always_comb begin
    snap_data_d  = '0;
    snap_valid_d = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (i_snap_sel == SEL_WIDTH'(k)) begin
        snap_data_d  = data_q[k];
        snap_valid_d = valid_q[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        data_q[k] <= '0;
      end
      valid_q      <= '0;
      step_q       <= '0;
      cyc_q        <= '0;
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
      valid_q      <= valid_d;
      step_q       <= step_d;
      cyc_q        <= cyc_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_out
    assign o_stage_data[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
  end

  assign o_stage_valid = valid_q;
  assign o_data        = data_q[NUM_STAGES-1];
  assign o_valid       = valid_q[NUM_STAGES-1];
  assign o_ready       = adv && !hold[0] && !i_flush[0];
  assign o_halted      = i_mode && (step_q == '0);
  assign o_step_left   = step_q;
  assign o_cycle_count = cyc_q;
  assign o_snap_data   = snap_data_q;
  assign o_snap_valid  = snap_valid_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain: directed scenarios plus random traffic,
// checked against a cycle-level reference model of the stage rules.
module tb_pipe_stage_chain;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam int YW = 32;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   i_data;
  logic            i_valid;
  logic [N-1:0]    i_stall, i_flush;
  logic            i_mode, i_step_load;
  logic [CW-1:0]   i_step_count;
  logic [SW-1:0]   i_snap_sel;
  logic [N*DW-1:0] o_stage_data;
  logic [N-1:0]    o_stage_valid;
  logic [DW-1:0]   o_data, o_snap_data;
  logic            o_valid, o_ready, o_halted, o_snap_valid;
  logic [CW-1:0]   o_step_left;
  logic [YW-1:0]   o_cycle_count;

  int ntests = 0;
  int nfail  = 0;

  logic [DW-1:0] md [N];
  logic [N-1:0]  mv;
  int unsigned   mstep;
  logic [YW-1:0] mcyc;
  logic [DW-1:0] msd;
  logic          msv;

  always #5 clk = ~clk;

  pipe_stage_chain #(
    .NUM_STAGES(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW),
    .CYC_WIDTH(YW), .SEL_WIDTH(SW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data(i_data), .i_valid(i_valid),
    .i_stall(i_stall), .i_flush(i_flush),
    .i_mode(i_mode), .i_step_load(i_step_load),
    .i_step_count(i_step_count), .i_snap_sel(i_snap_sel),
    .o_stage_data(o_stage_data), .o_stage_valid(o_stage_valid),
    .o_data(o_data), .o_valid(o_valid),
    .o_ready(o_ready), .o_halted(o_halted),
    .o_step_left(o_step_left), .o_cycle_count(o_cycle_count),
    .o_snap_data(o_snap_data), .o_snap_valid(o_snap_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) md[k] = '0;
    mv = '0; mstep = 0; mcyc = '0; msd = '0; msv = 1'b0;
  endtask

  function automatic bit m_adv();
    return (i_mode == 1'b0) || (mstep != 0);
  endfunction

  function automatic bit m_hold(input int k);
    for (int j = k; j < N; j++) if (i_stall[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_regs();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("data%0d", k), o_stage_data[k*DW +: DW], md[k]);
      chk($sformatf("valid%0d", k), 64'(o_stage_valid[k]), 64'(mv[k]));
    end
    chk("o_data", o_data, md[N-1]);
    chk("o_valid", 64'(o_valid), 64'(mv[N-1]));
    chk("step_left", 64'(o_step_left), 64'(mstep));
    chk("cycle_count", 64'(o_cycle_count), 64'(mcyc));
    chk("snap_data", o_snap_data, msd);
    chk("snap_valid", 64'(o_snap_valid), 64'(msv));
  endtask

  // One clock: check combinational outputs before the edge, then registers after.
  task automatic cycle();
    logic [DW-1:0] od [N];
    logic [N-1:0]  ov;
    bit            a;
    @(negedge clk);
    a = m_adv();
    chk("ready", 64'(o_ready), 64'(a && !m_hold(0) && !i_flush[0]));
    chk("halted", 64'(o_halted), 64'(i_mode && mstep == 0));
    for (int k = 0; k < N; k++) od[k] = md[k];
    ov = mv;
    @(posedge clk);
    if (int'(i_snap_sel) < N) begin
      msd = od[i_snap_sel]; msv = ov[i_snap_sel];
    end else begin
      msd = '0; msv = 1'b0;
    end
    if (a) begin
      for (int k = 0; k < N; k++) begin
        if (i_flush[k]) begin
          md[k] = '0; mv[k] = 1'b0;
        end else if (m_hold(k)) begin
          md[k] = od[k]; mv[k] = ov[k];
        end else if (k > 0 && m_hold(k - 1)) begin
          md[k] = '0; mv[k] = 1'b0;
        end else if (k == 0) begin
          md[k] = i_data; mv[k] = i_valid;
        end else begin
          md[k] = od[k-1]; mv[k] = ov[k-1];
        end
      end
      mcyc = mcyc + 1'b1;
    end
    if (i_step_load) mstep = i_step_count;
    else if (i_mode && mstep != 0) mstep = mstep - 1;
    #1;
    check_regs();
  endtask

  initial begin
    logic [YW-1:0] c0;
    logic [DW-1:0] frozen;
    rst_n = 1'b0; i_data = '0; i_valid = 1'b0;
    i_stall = '0; i_flush = '0; i_mode = 1'b0;
    i_step_load = 1'b0; i_step_count = '0; i_snap_sel = '0;
    model_reset();
    #1;
    check_regs();
    chk("halted_rst", 64'(o_halted), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill the pipe with 1,2,3,...
    for (int i = 1; i <= 4; i++) begin
      i_data = 64'(i); i_valid = 1'b1;
      cycle();
    end
    chk("fill_o_data", o_data, 64'h1);
    chk("fill_cyc", 64'(o_cycle_count), 64'd4);
    chk("fill_valid", 64'(o_stage_valid), 64'hf);
    i_data = 64'd5; cycle();

    // Stall at stage 1 for two cycles
    i_stall = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      i_data = 64'(6 + i); cycle();
      chk("stall_bubble_v2", 64'(o_stage_valid[2]), 64'd0);
      chk("stall_bubble_d2", o_stage_data[2*DW +: DW], 64'd0);
    end
    i_stall = '0; i_data = 64'd8; cycle();

    // Flush stages 0,1 while stage 0 stalls
    i_flush = 4'b0011; i_stall = 4'b0001; i_data = 64'd9;
    cycle();
    chk("flush_v01", 64'(o_stage_valid[1:0]), 64'd0);
    i_flush = '0; i_stall = '0;
    i_data = 64'd10; cycle();

    // Step mode with empty counter: frozen
    i_mode = 1'b1; c0 = mcyc; frozen = md[0];
    for (int i = 0; i < 10; i++) begin
      i_data = 64'(100 + i); cycle();
    end
    chk("halt_frozen", o_stage_data[0 +: DW], frozen);
    chk("halt_cyc", 64'(o_cycle_count), 64'(c0));
    chk("halt_flag", 64'(o_halted), 64'd1);
    i_step_load = 1'b1; i_step_count = 16'd3;
    cycle();
    chk("load_left", 64'(o_step_left), 64'd3);
    i_step_load = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      i_data = 64'(200 + i); cycle();
      chk("step_left", 64'(o_step_left), 64'(i));
    end
    chk("step_cyc", 64'(o_cycle_count), 64'(c0 + 3));
    chk("step_halted", 64'(o_halted), 64'd1);

    // Snapshot sweep while halted
    for (int s = 0; s < 5; s++) begin
      i_snap_sel = (s == 4) ? 3'd5 : 3'(s);
      cycle();
    end
    chk("snap_oob", o_snap_data, 64'd0);

    // Async reset mid-step
    i_step_load = 1'b1; i_step_count = 16'd5; cycle();
    i_step_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("rst_halted", 64'(o_halted), 64'd1);
    rst_n = 1'b1;
    i_step_load = 1'b1; i_step_count = 16'd2; cycle();
    i_step_load = 1'b0;
    chk("reload_left", 64'(o_step_left), 64'd2);
    cycle(); cycle(); cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      i_data       = {$urandom, $urandom};
      i_valid      = 1'($urandom);
      i_stall      = 4'($urandom & $urandom & $urandom);
      i_flush      = 4'($urandom & $urandom & $urandom);
      i_mode       = ($urandom_range(0, 3) == 0);
      i_step_load  = ($urandom_range(0, 9) == 0);
      i_step_count = 16'($urandom_range(0, 6));
      i_snap_sel   = 3'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised replacement for the hand-wired IF/ID/EX/MEM/WB latch set in the processor top. It is an N-stage chain of DATA_WIDTH pipeline registers with per-stage valid bits, per-stage stall and flush, and automatic bubble insertion. It adds a debugger-driven run/step mode with a bounded step counter, a cycle counter and a registered stage-snapshot read port. It sits between the stage datapaths and the debugger.

Parameters:
NUM_STAGES, 4, number of pipeline registers in the chain (stage 0 is fed by i_data), >=2
DATA_WIDTH, 64, width of each stage register
CNT_WIDTH, 16, width of step counter and i_step_count
CYC_WIDTH, 32, width of cycle counter
SEL_WIDTH, $clog2(NUM_STAGES), snapshot select width

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_data  in  DATA_WIDTH  payload entering stage 0
i_valid  in  1  i_data is a real instruction
i_stall  in  NUM_STAGES  per-stage stall request, bit k = stage k
i_flush  in  NUM_STAGES  per-stage flush request
i_mode  in  1  0 = continuous run, 1 = debug step mode
i_step_load  in  1  one-cycle pulse: load step counter
i_step_count  in  CNT_WIDTH  cycles to run in step mode
i_snap_sel  in  SEL_WIDTH  stage index for snapshot
o_stage_data  out  NUM_STAGES*DATA_WIDTH  all stage registers, stage k at [k*DATA_WIDTH +: DATA_WIDTH]
o_stage_valid  out  NUM_STAGES  valid bit per stage
o_data  out  DATA_WIDTH  last stage register
o_valid  out  1  last stage valid
o_ready  out  1  stage 0 captures i_data this cycle
o_halted  out  1  step mode and counter exhausted
o_step_left  out  CNT_WIDTH  remaining step cycles
o_cycle_count  out  CYC_WIDTH  count of advancing cycles
o_snap_data  out  DATA_WIDTH  registered copy of selected stage
o_snap_valid  out  1  registered valid of selected stage

Behaviour:
- Reset (i_rst_n=0, async): all stage data/valid = 0, step counter = 0, cycle counter = 0, snapshot outputs = 0. o_halted = i_mode (combinational from counter = 0). Reset mid-step discards the remaining count.
- adv = (i_mode==0) || (step_left != 0). When adv=0 no stage register changes, and flushes are ignored.
- hold_k = OR of i_stall[k..NUM_STAGES-1]. A stall at stage j freezes stages 0..j.
- Per-stage update when adv=1, highest priority first:
  1. i_flush[k] -> valid_k=0, data_k=0. Flush wins over stall on the same stage.
  2. hold_k -> keep.
  3. k>0 and hold_(k-1) -> bubble: valid_k=0, data_k=0.
  4. else stage 0 takes i_data/i_valid; stage k takes stage k-1.
- o_ready = adv && !hold_0 && !i_flush[0] (combinational).
- Step counter:
  - i_step_load=1 -> step_left <= i_step_count. This overrides the decrement, and the load cycle advances only if the old step_left != 0.
  - Else if i_mode=1 and step_left!=0 -> decrement by 1. Stalled cycles still consume a step.
  - In mode 0 the counter holds its value (load still allowed).
  - Switching 1->0 resumes immediately. Switching 0->1 with step_left=0 halts on the same cycle.
- o_halted = i_mode && step_left==0.
- o_cycle_count increments on every cycle with adv=1 and wraps modulo 2^CYC_WIDTH.
- Snapshot: captured every cycle from the pre-edge stage[i_snap_sel] value, so latency is 1 cycle. It is captured even while halted, so the debugger can scan stages during a halt. i_snap_sel >= NUM_STAGES gives 0/0.
- Latency i_data -> o_data is NUM_STAGES cycles with no stalls.
- Combinational paths: o_ready and o_halted only. All other outputs are registered.

Test Plan:
1. Reset, NUM_STAGES=4, mode 0, feed 0x1,0x2,0x3,... with valid=1 -> o_data=0x1 on cycle 4 after first capture; o_cycle_count=4; o_stage_valid=4'b1111 after 4 cycles.
2. Steady flow, assert i_stall=4'b0010 for 2 cycles -> stages 0,1 hold, stage 2 gets two bubbles (valid 0, data 0), stage 3 drains; o_ready=0 both cycles.
3. i_flush=4'b0011 together with i_stall=4'b0001 -> stages 0,1 cleared to valid 0 next edge; stages 2,3 advance normally.
4. Mode 1, step_left=0 -> o_halted=1, registers frozen for 10 cycles. Pulse load with count 3 -> exactly 3 advances, o_step_left 3,2,1,0, o_cycle_count +3, then o_halted=1.
5. While halted, sweep i_snap_sel 0..3 then 5 -> o_snap_data equals each stage one cycle later, then 0 for index 5; no stage changes.
6. Assert i_rst_n low asynchronously mid-step (step_left=5, between edges) -> all outputs 0 immediately, o_halted=1 with mode 1; a load after release restarts from the loaded count.
